axis_frame_gen: RTL and testbench

//  AXI4-Stream frame transmitter; the source end of the frame-FIFO path.
//  - Generates N frames of programmable length, with a programmable inter-frame gap.
//  - Drives an axis_frame_fifo input (or any AXIS sink) and honours tready backpressure.
//  - Supports mid-frame abort by closing the frame with tuser=bad.
//  - Counts good frames sent and frames reported dropped on the sink's drop_frame output.

---
 rtl/axis_frame_gen_if.sv | 13 +
 rtl/axis_frame_gen.sv | 210 +++++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream beat channel driven by axis_frame_gen (master) into a frame sink (slave).
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: N frames of programmable length and gap, abort, good/drop counters.
// Optional macro AXIS_FRAME_GEN_LFSR_EN switches beat data from incrementing to a Galois LFSR.
module axis_frame_gen #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    LEN_WIDTH   = 16,
  parameter int                    GAP_WIDTH   = 8,
  parameter int                    COUNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY   = 8'hB8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  input  logic [COUNT_WIDTH-1:0] frame_count,
  input  logic [GAP_WIDTH-1:0]   gap_len,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic                   abort,
  axis_frame_gen_if.master       output_axis,
  input  logic                   drop_frame,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frames_sent,
  output logic [COUNT_WIDTH-1:0] frames_dropped
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_TERM = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  function automatic logic [DATA_WIDTH-1:0] next_data(input logic [DATA_WIDTH-1:0] cur);
`ifdef AXIS_FRAME_GEN_LFSR_EN
    if (cur[0]) begin
      next_data = {1'b0, cur[DATA_WIDTH-1:1]} ^ LFSR_POLY;
    end else begin
      next_data = {1'b0, cur[DATA_WIDTH-1:1]};
    end
`else
    next_data = cur + DATA_WIDTH'(1);
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] first_data(input logic [DATA_WIDTH-1:0] s);
`ifdef AXIS_FRAME_GEN_LFSR_EN
    // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
    first_data = (s == {DATA_WIDTH{1'b0}}) ? DATA_WIDTH'(1) : s;
`else
    first_data = s;
`endif
  endfunction

  state_t                 state_r;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [LEN_WIDTH-1:0]   beat_r;
  logic [COUNT_WIDTH-1:0] rem_r;
  logic [GAP_WIDTH-1:0]   gap_r;
  logic [GAP_WIDTH-1:0]   gap_cnt_r;
  logic [DATA_WIDTH-1:0]  seed_r;
  logic                   abort_pend_r;
  logic [DATA_WIDTH-1:0]  tdata_r;
  logic                   tvalid_r;
  logic                   tlast_r;
  logic                   tuser_r;
  logic                   busy_r;
  logic [COUNT_WIDTH-1:0] sent_r;
  logic [COUNT_WIDTH-1:0] dropped_r;

  logic [LEN_WIDTH-1:0]   len_eff_s;
  logic [LEN_WIDTH-1:0]   beat_next_s;
  logic                   tlast_next_s;
  logic                   accept_s;
  logic                   abort_now_s;

  assign len_eff_s    = (frame_len == {LEN_WIDTH{1'b0}}) ? LEN_WIDTH'(1) : frame_len;
  assign beat_next_s  = beat_r + LEN_WIDTH'(1);
  assign tlast_next_s = (beat_next_s == (len_r - LEN_WIDTH'(1)));
  assign accept_s     = tvalid_r & output_axis.tready;
  assign abort_now_s  = abort | abort_pend_r;

  // Frame sequencer: state, beat registers and the good-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      len_r        <= {LEN_WIDTH{1'b0}};
      beat_r       <= {LEN_WIDTH{1'b0}};
      rem_r        <= {COUNT_WIDTH{1'b0}};
      gap_r        <= {GAP_WIDTH{1'b0}};
      gap_cnt_r    <= {GAP_WIDTH{1'b0}};
      seed_r       <= {DATA_WIDTH{1'b0}};
      abort_pend_r <= 1'b0;
      tdata_r      <= {DATA_WIDTH{1'b0}};
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tuser_r      <= 1'b0;
      busy_r       <= 1'b0;
      sent_r       <= {COUNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Abort in the same cycle as start cancels the run before it begins.
          if (start && !abort) begin
            len_r        <= len_eff_s;
            rem_r        <= frame_count;
            gap_r        <= gap_len;
            seed_r       <= first_data(seed);
            tdata_r      <= first_data(seed);
            beat_r       <= {LEN_WIDTH{1'b0}};
            tlast_r      <= (len_eff_s == LEN_WIDTH'(1));
            tuser_r      <= 1'b0;
            tvalid_r     <= 1'b1;
            abort_pend_r <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept_s) begin
            abort_pend_r <= 1'b0;
            if (tlast_r) begin
              if (sent_r != CNT_MAX) begin
                sent_r <= sent_r + COUNT_WIDTH'(1);
              end
              // rem_r == 0 means an endless run, so it never matches 1 here.
              if (abort_now_s || (rem_r == COUNT_WIDTH'(1))) begin
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
                busy_r   <= 1'b0;
                state_r  <= ST_IDLE;
              end else begin
                if (rem_r != {COUNT_WIDTH{1'b0}}) begin
                  rem_r <= rem_r - COUNT_WIDTH'(1);
                end
                beat_r  <= {LEN_WIDTH{1'b0}};
                tdata_r <= seed_r;
                if (gap_r == {GAP_WIDTH{1'b0}}) begin
                  tlast_r <= (len_r == LEN_WIDTH'(1));
                end else begin
                  tvalid_r  <= 1'b0;
                  tlast_r   <= 1'b0;
                  gap_cnt_r <= gap_r - GAP_WIDTH'(1);
                  state_r   <= ST_GAP;
                end
              end
            end else if (abort_now_s) begin
              tdata_r <= next_data(tdata_r);
              tlast_r <= 1'b1;
              tuser_r <= 1'b1;
              state_r <= ST_TERM;
            end else begin
              beat_r  <= beat_next_s;
              tdata_r <= next_data(tdata_r);
              tlast_r <= tlast_next_s;
            end
          end else if (abort) begin
            abort_pend_r <= 1'b1;
          end
        end
        ST_GAP: begin
          if (abort) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (gap_cnt_r == {GAP_WIDTH{1'b0}}) begin
            tvalid_r <= 1'b1;
            tlast_r  <= (len_r == LEN_WIDTH'(1));
            state_r  <= ST_SEND;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
          end
        end
        ST_TERM: begin
          if (output_axis.tready) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tuser_r  <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
          tuser_r  <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Sink drop reports are counted independently of the sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_r <= {COUNT_WIDTH{1'b0}};
    end else if (drop_frame && (dropped_r != CNT_MAX)) begin
      dropped_r <= dropped_r + COUNT_WIDTH'(1);
    end
  end

  assign output_axis.tdata  = tdata_r;
  assign output_axis.tvalid = tvalid_r;
  assign output_axis.tlast  = tlast_r;
  assign output_axis.tuser  = tuser_r;
  assign busy               = busy_r;
  assign frames_sent        = sent_r;
  assign frames_dropped     = dropped_r;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: directed scenarios plus randomized runs against a beat-list model.
module tb_axis_frame_gen;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int GW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          drop_frame;
  logic [LW-1:0] frame_len;
  logic [CW-1:0] frame_count;
  logic [GW-1:0] gap_len;
  logic [DW-1:0] seed;
  logic          busy;
  logic [CW-1:0] frames_sent;
  logic [CW-1:0] frames_dropped;

  axis_frame_gen_if #(.DATA_WIDTH(DW)) axis ();

  axis_frame_gen #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .frame_count(frame_count),
    .gap_len(gap_len), .seed(seed), .abort(abort), .output_axis(axis),
    .drop_frame(drop_frame), .busy(busy), .frames_sent(frames_sent), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int q_beat[$];
  int e_beat[$];
  int q_gap[$];
  int stab_err;
  int stall_cnt;
  bit timed_out;

  // Expected accepted beats: {tuser, tlast, tdata} for cnt frames of data seed+k.
  task automatic model(input int s, input int len, input int cnt);
    int l;
    l = (len == 0) ? 1 : len;
    e_beat.delete();
    for (int f = 0; f < cnt; f++)
      for (int k = 0; k < l; k++)
        e_beat.push_back(((s + k) % 256) + ((k == l - 1) ? 256 : 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0; drop_frame = 1'b0; axis.tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic launch(input int s, input int len, input int cnt, input int gap);
    @(negedge clk);
    seed = DW'(s); frame_len = LW'(len); frame_count = CW'(cnt); gap_len = GW'(gap);
    start = 1'b1;
  endtask

  // Drives tready and side pulses each cycle and records accepted beats and idle gaps until busy falls.
  // mode: 0 ready, 1 random ready, 2 stall 3 cycles on first beat == special.
  // abort_mode: 0 none, 1 on first beat == special, 2 on first gap cycle.
  task automatic collect(input int mode, input int special, input int abort_mode,
                         input bit drop_on_last, input int budget);
    bit gap_open = 0; int gap_run = 0; bit prev_stall = 0; int pbeat = 0;
    int stall_left = 3; bit aborted = 0; bit done = 0; int cur;
    q_beat.delete(); q_gap.delete(); stab_err = 0; stall_cnt = 0; timed_out = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; drop_frame = 1'b0;
      cur = int'({axis.tuser, axis.tlast, axis.tdata});
      if (prev_stall && (axis.tvalid !== 1'b1 || cur != pbeat)) stab_err++;
      if (busy !== 1'b1) begin
        done = 1;
      end else begin
        if (gap_open) begin
          if (axis.tvalid) begin q_gap.push_back(gap_run); gap_open = 0; end
          else gap_run++;
        end
        case (mode)
          1: axis.tready = ($urandom_range(0, 3) != 0);
          2: if (axis.tvalid && axis.tdata == DW'(special) && stall_left > 0) begin
               axis.tready = 1'b0; stall_left--; stall_cnt++;
             end else axis.tready = 1'b1;
          default: axis.tready = 1'b1;
        endcase
        if (abort_mode == 1 && !aborted && axis.tvalid && axis.tdata == DW'(special)) begin
          abort = 1'b1; aborted = 1;
        end
        if (abort_mode == 2 && !aborted && gap_open && !axis.tvalid) begin
          abort = 1'b1; aborted = 1;
        end
        if (mode == 1 && $urandom_range(0, 7) == 0) begin
          start = 1'b1; seed = DW'($urandom); frame_len = LW'($urandom_range(0, 9));
          gap_len = GW'($urandom_range(0, 5)); frame_count = CW'($urandom_range(0, 5));
        end
        if (axis.tvalid && axis.tready) begin
          q_beat.push_back(cur);
          if (axis.tlast) begin
            gap_open = 1; gap_run = 0;
            if (drop_on_last && !axis.tuser) drop_frame = 1'b1;
          end
        end
        prev_stall = axis.tvalid && !axis.tready;
        pbeat = cur;
      end
    end
    if (!done) timed_out = 1;
    start = 1'b0; abort = 1'b0; drop_frame = 1'b0; axis.tready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (axis.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got %b want 0", axis.tvalid); end
    checks++; if (axis.tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got %b want 0", axis.tlast); end
    checks++; if (axis.tuser !== 1'b0) begin failures++; $display("FAIL reset_tuser got %b want 0", axis.tuser); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frames_sent !== '0) begin failures++; $display("FAIL reset_sent got %0d want 0", frames_sent); end
    checks++; if (frames_dropped !== '0) begin failures++; $display("FAIL reset_dropped got %0d want 0", frames_dropped); end
  endtask

  task automatic test_basic();
    do_reset();
    launch(1, 3, 2, 2);
    collect(0, 0, 0, 0, 100);
    model(1, 3, 2);
    checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout busy still high"); end
    checks++; if (q_beat.size() != e_beat.size()) begin failures++; $display("FAIL basic_count got %0d want %0d", q_beat.size(), e_beat.size()); end
    for (int i = 0; i < e_beat.size() && i < q_beat.size(); i++) begin
      checks++; if (q_beat[i] != e_beat[i]) begin failures++; $display("FAIL basic_beat%0d got %h want %h", i, q_beat[i], e_beat[i]); end
    end
    checks++; if (q_gap.size() != 1 || q_gap[0] != 2) begin failures++; $display("FAIL basic_gap got %p want '{2}", q_gap); end
    checks++; if (frames_sent !== CW'(2)) begin failures++; $display("FAIL basic_sent got %0d want 2", frames_sent); end
  endtask

  task automatic test_backpressure();
    do_reset();
    launch(1, 3, 2, 2);
    collect(2, 2, 0, 0, 100);
    model(1, 3, 2);
    checks++; if (stall_cnt != 3) begin failures++; $display("FAIL bp_stalls got %0d want 3", stall_cnt); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
    checks++; if (q_beat != e_beat) begin failures++; $display("FAIL bp_beats got %p want %p", q_beat, e_beat); end
    checks++; if (frames_sent !== CW'(2) || timed_out) begin failures++; $display("FAIL bp_sent got %0d want 2 (timeout %0d)", frames_sent, timed_out); end
  endtask

  task automatic test_random();
    int s, len, cnt, gap;
    for (int it = 0; it < 8; it++) begin
      s = $urandom_range(0, 255); len = $urandom_range(0, 6);
      cnt = $urandom_range(1, 3); gap = $urandom_range(0, 3);
      do_reset();
      launch(s, len, cnt, gap);
      collect(1, 0, 0, 0, 400);
      model(s, len, cnt);
      checks++; if (q_beat != e_beat) begin failures++; $display("FAIL rnd%0d_beats got %p want %p", it, q_beat, e_beat); end
      checks++; if (q_gap.size() != cnt - 1) begin failures++; $display("FAIL rnd%0d_ngaps got %0d want %0d", it, q_gap.size(), cnt - 1); end
      foreach (q_gap[g]) begin
        checks++; if (q_gap[g] != gap) begin failures++; $display("FAIL rnd%0d_gap got %0d want %0d", it, q_gap[g], gap); end
      end
      checks++; if (frames_sent !== CW'(cnt) || timed_out) begin failures++; $display("FAIL rnd%0d_sent got %0d want %0d (timeout %0d)", it, frames_sent, cnt, timed_out); end
      checks++; if (stab_err != 0) begin failures++; $display("FAIL rnd%0d_stable got %0d want 0", it, stab_err); end
    end
  endtask

  task automatic test_abort();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      launch(1, 5, 0, 1);
      collect(v == 0 ? 0 : 2, 2, 1, 0, 100);
      e_beat = '{1, 2, 3 + 256 + 512};
      checks++; if (q_beat != e_beat) begin failures++; $display("FAIL abort%0d_beats got %p want %p", v, q_beat, e_beat); end
      checks++; if (frames_sent !== '0 || timed_out) begin failures++; $display("FAIL abort%0d_sent got %0d want 0 (timeout %0d)", v, frames_sent, timed_out); end
    end
    do_reset();
    launch(5, 1, 0, 3);
    collect(0, 0, 2, 0, 100);
    e_beat = '{5 + 256};
    checks++; if (q_beat != e_beat || timed_out) begin failures++; $display("FAIL abort_gap got %p want %p", q_beat, e_beat); end
    checks++; if (frames_sent !== CW'(1)) begin failures++; $display("FAIL abort_gap_sent got %0d want 1", frames_sent); end
    do_reset();
    launch(9, 2, 1, 0);
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || axis.tvalid !== 1'b0) begin failures++; $display("FAIL start_abort got busy %b tvalid %b want 0 0", busy, axis.tvalid); end
  endtask

  task automatic test_drop();
    do_reset();
    drop_frame = 1'b1;
    @(negedge clk);
    drop_frame = 1'b0;
    launch(1, 2, 1, 0);
    collect(0, 0, 0, 1, 100);
    checks++; if (frames_dropped !== CW'(2)) begin failures++; $display("FAIL drop_count got %0d want 2", frames_dropped); end
    checks++; if (frames_sent !== CW'(1) || timed_out) begin failures++; $display("FAIL drop_sent got %0d want 1", frames_sent); end
  endtask

  task automatic test_wrap();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      launch(255, v == 0 ? 0 : 2, 1, 0);
      collect(0, 0, 0, 0, 100);
      if (v == 0) e_beat = '{255 + 256};
      else e_beat = '{255, 0 + 256};
      checks++; if (q_beat != e_beat || timed_out) begin failures++; $display("FAIL wrap%0d got %p want %p", v, q_beat, e_beat); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    launch(3, 1, 1, 0);
    collect(0, 0, 0, 0, 50);
    drop_frame = 1'b1;
    @(negedge clk);
    drop_frame = 1'b0;
    checks++; if (frames_sent !== CW'(1) || frames_dropped !== CW'(1)) begin failures++; $display("FAIL rmid_pre got %0d/%0d want 1/1", frames_sent, frames_dropped); end
    launch(1, 5, 0, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++; if (axis.tvalid !== 1'b1) begin failures++; $display("FAIL rmid_active got tvalid %b want 1", axis.tvalid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (axis.tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_idle got tvalid %b busy %b want 0 0", axis.tvalid, busy); end
    checks++; if (frames_sent !== '0 || frames_dropped !== '0) begin failures++; $display("FAIL rmid_counters got %0d/%0d want 0/0", frames_sent, frames_dropped); end
    launch(64, 2, 1, 0);
    collect(0, 0, 0, 0, 50);
    e_beat = '{64, 65 + 256};
    checks++; if (q_beat != e_beat || timed_out) begin failures++; $display("FAIL rmid_restart got %p want %p", q_beat, e_beat); end
  endtask

  task automatic test_saturation();
    do_reset();
    launch(7, 1, 0, 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      start = 1'b0; drop_frame = 1'b1;
    end
    @(negedge clk);
    drop_frame = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int n = 0; n < 10 && busy; n++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sat_busy got %b want 0", busy); end
    checks++; if (frames_sent !== CW'(15)) begin failures++; $display("FAIL sat_sent got %0d want 15", frames_sent); end
    checks++; if (frames_dropped !== CW'(15)) begin failures++; $display("FAIL sat_dropped got %0d want 15", frames_dropped); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; drop_frame = 1'b0; axis.tready = 1'b1;
    frame_len = '0; frame_count = '0; gap_len = '0; seed = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_drop();
    test_wrap();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
